// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine.
package gcd_pkg;

   // Default operand/result width in bits.
   localparam int GCD_WIDTH = 8;

   // Control states of the subtract-and-swap engine.
   typedef enum logic [1:0] {
      READY = 2'd0,
      CALC  = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : gcd_pkg

// File: rtl/gcd_if.sv
// Operand/result handshake bundle between producer, GCD engine and consumer.
interface gcd_if
   import gcd_pkg::*;
#(
   parameter int width = GCD_WIDTH
) ();

   logic [width-1:0] operand_A;
   logic [width-1:0] operand_B;
   logic             input_available;
   logic             input_ready;
   logic             result_rdy;
   logic [width-1:0] result_data;
   logic             result_taken;

   // Engine side.
   modport slave (
      input  operand_A,
      input  operand_B,
      input  input_ready,
      input  result_taken,
      output input_available,
      output result_rdy,
      output result_data
   );

   // Producer/consumer side.
   modport master (
      output operand_A,
      output operand_B,
      output input_ready,
      output result_taken,
      input  input_available,
      input  result_rdy,
      input  result_data
   );

endinterface : gcd_if

// File: rtl/gcd_datapath.sv
// Operand registers, compare, swap/subtract mux and result register.
module gcd_datapath
   import gcd_pkg::*;
#(
   parameter int width = GCD_WIDTH
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic             load,
   input  logic             step,
   input  logic [width-1:0] operand_a,
   input  logic [width-1:0] operand_b,
   output logic [width-1:0] result,
   output logic             b_zero,
   output logic             a_lt_b
);

   logic [width-1:0] a_q;
   logic [width-1:0] b_q;

   assign a_lt_b = (a_q < b_q);
   assign b_zero = (b_q == '0);

   // Load operands, then swap/subtract once per step; capture A when B reaches zero.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         a_q    <= '0;
         b_q    <= '0;
         result <= '0;
      end else if (load) begin
         a_q <= operand_a;
         b_q <= operand_b;
      end else if (step) begin
         if (a_lt_b) begin
            // NOTE: non-blocking assignments both read the pre-edge values, so this is a true swap.
            a_q <= b_q;
            b_q <= a_q;
         end else if (!b_zero) begin
            a_q <= a_q - b_q;
         end else begin
            result <= a_q;
         end
      end
   end

endmodule : gcd_datapath

// File: rtl/gcd_top.sv
// Iterative GCD engine: handshake FSM around the subtract-and-swap datapath.
module gcd_top
   import gcd_pkg::*;
#(
   parameter int width = GCD_WIDTH
) (
   input  logic sys_clk,
   input  logic sys_rst,
   gcd_if.slave bus
);

   state_t           state;
   logic             avail_q;
   logic             rdy_q;
   logic             load;
   logic             step;
   logic             b_zero;
   logic             a_lt_b;
   logic [width-1:0] result;

   // A start is only honoured in READY; iteration runs for every CALC cycle.
   assign load = (state == READY) && bus.input_ready;
   assign step = (state == CALC);

   gcd_datapath #(
      .width (width)
   ) u_datapath (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .load      (load),
      .step      (step),
      .operand_a (bus.operand_A),
      .operand_b (bus.operand_B),
      .result    (result),
      .b_zero    (b_zero),
      .a_lt_b    (a_lt_b)
   );

   // Control FSM with handshake flags registered alongside the state.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state   <= READY;
         avail_q <= 1'b1;
         rdy_q   <= 1'b0;
      end else begin
         case (state)
            READY: begin
               if (bus.input_ready) begin
                  state   <= CALC;
                  avail_q <= 1'b0;
               end
            end
            CALC: begin
               if (!a_lt_b && b_zero) begin
                  state <= DONE;
                  rdy_q <= 1'b1;
               end
            end
            DONE: begin
               if (bus.result_taken) begin
                  state   <= READY;
                  rdy_q   <= 1'b0;
                  avail_q <= 1'b1;
               end
            end
            default: begin
               state   <= READY;
               avail_q <= 1'b1;
               rdy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.input_available = avail_q;
   assign bus.result_rdy      = rdy_q;
   assign bus.result_data     = result;

endmodule : gcd_top

// File: tb/tb_gcd_top.sv
// Directed self-checking bench for gcd_top.
module tb_gcd_top;

   localparam int W      = 8;
   localparam int BUDGET = 1000;

   logic sys_clk;
   logic sys_rst;
   int   n_tests;
   int   n_fail;

   logic [W-1:0] pa [4] = '{8'd12, 8'd105, 8'd24, 8'd126};
   logic [W-1:0] pb [4] = '{8'd66, 8'd99,  8'd18, 8'd18};
   logic [W-1:0] pe [4] = '{8'd6,  8'd3,   8'd6,  8'd18};

   gcd_if #(.width(W)) bus ();

   gcd_top #(.width(W)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Reference value by remainder Euclid.
   function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      int x, y, t;
      x = a;
      y = b;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x[W-1:0];
   endfunction

   // Number of swap/subtract iterations the subtract-and-swap algorithm takes.
   function automatic int iter_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      int x, y, t, n;
      x = a;
      y = b;
      n = 0;
      while (1) begin
         if (x < y) begin
            t = x; x = y; y = t; n++;
         end else if (y != 0) begin
            x = x - y; n++;
         end else begin
            break;
         end
      end
      return n;
   endfunction

   task automatic do_reset(input int cycles);
      sys_rst = 1'b1;
      repeat (cycles) @(negedge sys_clk);
      sys_rst = 1'b0;
   endtask

   // One job: optional idle before start, wait for result, hold before taking it.
   task automatic run_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp,
                          input int pre, input int hold, input string name, output int lat);
      logic [W-1:0] g;
      int           it;
      g  = gcd_ref(a, b);
      it = iter_ref(a, b);
      repeat (pre) @(negedge sys_clk);
      bus.operand_A   = a;
      bus.operand_B   = b;
      bus.input_ready = 1'b1;
      @(negedge sys_clk);
      bus.input_ready = 1'b0;
      n_tests++;
      if (bus.input_available !== 1'b0) begin
         n_fail++;
         $display("FAIL %s avail_after_start: got %b want 0", name, bus.input_available);
      end
      lat = 0;
      while (bus.result_rdy !== 1'b1 && lat < BUDGET) begin
         @(negedge sys_clk);
         lat++;
      end
      n_tests++;
      if (bus.result_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s timeout: result_rdy=%b after %0d cycles", name, bus.result_rdy, lat);
         do_reset(1);
         return;
      end
      n_tests++;
      if (bus.result_data !== exp) begin
         n_fail++;
         $display("FAIL %s result: got %0d want %0d", name, bus.result_data, exp);
      end
      n_tests++;
      if (bus.result_data !== g) begin
         n_fail++;
         $display("FAIL %s scoreboard: got %0d want %0d", name, bus.result_data, g);
      end
      n_tests++;
      if (lat != it + 1) begin
         n_fail++;
         $display("FAIL %s latency: got %0d want %0d", name, lat, it + 1);
      end
      for (int i = 0; i < hold; i++) begin
         @(negedge sys_clk);
         n_tests++;
         if (bus.result_rdy !== 1'b1 || bus.input_available !== 1'b0 || bus.result_data !== exp) begin
            n_fail++;
            $display("FAIL %s hold[%0d]: rdy=%b avail=%b data=%0d want 1/0/%0d",
                     name, i, bus.result_rdy, bus.input_available, bus.result_data, exp);
         end
      end
      bus.result_taken = 1'b1;
      @(negedge sys_clk);
      bus.result_taken = 1'b0;
      n_tests++;
      if (bus.input_available !== 1'b1 || bus.result_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s release: avail=%b rdy=%b want 1/0", name, bus.input_available, bus.result_rdy);
      end
   endtask

   task automatic test_reset();
      sys_rst          = 1'b1;
      bus.operand_A    = '0;
      bus.operand_B    = '0;
      bus.input_ready  = 1'b0;
      bus.result_taken = 1'b0;
      @(negedge sys_clk);
      do_reset(2);
      for (int i = 0; i < 6; i++) begin
         n_tests++;
         if (bus.input_available !== 1'b1 || bus.result_rdy !== 1'b0 || bus.result_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: avail=%b rdy=%b data=%0d want 1/0/0",
                     i, bus.input_available, bus.result_rdy, bus.result_data);
         end
         @(negedge sys_clk);
      end
   endtask

   task automatic test_single();
      int lat;
      for (int i = 0; i < 4; i++) run_job(pa[i], pb[i], pe[i], 0, 0, "single", lat);
   endtask

   task automatic test_edges();
      int lat;
      run_job(8'd0,   8'd35, 8'd35, 0, 0, "zero_a", lat);
      run_job(8'd35,  8'd0,  8'd35, 0, 0, "zero_b", lat);
      run_job(8'd0,   8'd0,  8'd0,  0, 0, "zero_zero", lat);
      n_tests++;
      if (lat != 1) begin
         n_fail++;
         $display("FAIL zero_zero_latency: got %0d want 1", lat);
      end
      run_job(8'd255, 8'd1,  8'd1,  0, 0, "max_1", lat);
      // 255 subtractions, one swap, then the completion step.
      n_tests++;
      if (lat != 257) begin
         n_fail++;
         $display("FAIL max_1_latency: got %0d want 257", lat);
      end
   endtask

   task automatic test_hold();
      int lat;
      run_job(8'd24, 8'd18, 8'd6, 0, 20, "hold", lat);
   endtask

   task automatic test_ignored_strobes();
      int lat;
      // result_taken while READY must not disturb anything.
      bus.result_taken = 1'b1;
      @(negedge sys_clk);
      bus.result_taken = 1'b0;
      n_tests++;
      if (bus.input_available !== 1'b1 || bus.result_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL taken_in_ready: avail=%b rdy=%b want 1/0", bus.input_available, bus.result_rdy);
      end
      // Start 126/18, then pulse a bogus start with new operands mid-CALC.
      bus.operand_A   = 8'd126;
      bus.operand_B   = 8'd18;
      bus.input_ready = 1'b1;
      @(negedge sys_clk);
      bus.input_ready = 1'b0;
      @(negedge sys_clk);
      bus.operand_A   = 8'd7;
      bus.operand_B   = 8'd5;
      bus.input_ready = 1'b1;
      @(negedge sys_clk);
      bus.input_ready = 1'b0;
      lat = 0;
      while (bus.result_rdy !== 1'b1 && lat < BUDGET) begin
         @(negedge sys_clk);
         lat++;
      end
      n_tests++;
      if (bus.result_rdy !== 1'b1 || bus.result_data !== 8'd18) begin
         n_fail++;
         $display("FAIL start_in_calc: rdy=%b data=%0d want 1/18", bus.result_rdy, bus.result_data);
      end
      // A start strobe in DONE is also ignored.
      bus.input_ready = 1'b1;
      @(negedge sys_clk);
      bus.input_ready = 1'b0;
      n_tests++;
      if (bus.result_rdy !== 1'b1 || bus.input_available !== 1'b0 || bus.result_data !== 8'd18) begin
         n_fail++;
         $display("FAIL start_in_done: rdy=%b avail=%b data=%0d want 1/0/18",
                  bus.result_rdy, bus.input_available, bus.result_data);
      end
      bus.result_taken = 1'b1;
      @(negedge sys_clk);
      bus.result_taken = 1'b0;
      n_tests++;
      if (bus.input_available !== 1'b1 || bus.result_rdy !== 1'b0 || bus.result_data !== 8'd18) begin
         n_fail++;
         $display("FAIL release_keeps_data: avail=%b rdy=%b data=%0d want 1/0/18",
                  bus.input_available, bus.result_rdy, bus.result_data);
      end
   endtask

   task automatic test_reset_mid_calc();
      int lat;
      bus.operand_A   = 8'd200;
      bus.operand_B   = 8'd3;
      bus.input_ready = 1'b1;
      @(negedge sys_clk);
      bus.input_ready = 1'b0;
      repeat (10) @(negedge sys_clk);
      n_tests++;
      if (bus.result_rdy !== 1'b0 || bus.input_available !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_calc_busy: rdy=%b avail=%b want 0/0", bus.result_rdy, bus.input_available);
      end
      do_reset(1);
      n_tests++;
      if (bus.input_available !== 1'b1 || bus.result_rdy !== 1'b0 || bus.result_data !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_mid_calc: avail=%b rdy=%b data=%0d want 1/0/0",
                  bus.input_available, bus.result_rdy, bus.result_data);
      end
      run_job(8'd24, 8'd18, 8'd6, 0, 0, "after_reset", lat);
   endtask

   task automatic test_back_to_back();
      int lat;
      int da;
      int dt;
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) begin
            da = $urandom_range(0, 3);
            dt = $urandom_range(0, 3);
            run_job(pa[i], pb[i], pe[i], da, dt, "b2b", lat);
         end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_single();
      test_edges();
      test_hold();
      test_ignored_strobes();
      test_reset_mid_calc();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_gcd_top

// File: doc/gcd_top.md
Name: gcd_top

Overview:
- Iterative greatest-common-divisor engine with a two-sided handshake: one operand pair in, one result out.
- Computes gcd(A,B) by subtract-and-swap Euclid, one iteration per clock.
- Sits between an operand producer and a result consumer; neither side is backpressured beyond the handshake.

Parameters:
- width, 8, bit width of operands and result (unsigned).

Ports:
- sys_clk  input  1  system clock; all logic on the rising edge.
- sys_rst  input  1  reset, synchronous, active-high.
- operand_A  input  width  first operand; sampled when a start is accepted.
- operand_B  input  width  second operand; sampled when a start is accepted.
- input_available  output  1  high while the block can accept a new operand pair.
- input_ready  input  1  start strobe; producer asserts it once operands are valid.
- result_rdy  output  1  high while result_data holds a finished result awaiting consumption.
- result_data  output  width  GCD result.
- result_taken  input  1  consumer acknowledge; releases the result.

Behaviour:
- Reset is synchronous, active-high, one clock, single clock domain.
- Reset state is READY. result_data=0, internal A/B=0, so input_available=1 and result_rdy=0 from the first edge after reset.
- Reset asserted mid-CALC or in DONE aborts the operation; the in-flight result is discarded.
- FSM states: READY, CALC, DONE. Outputs are Moore, decoded from registered state:
  - input_available = (state==READY)
  - result_rdy = (state==DONE)
- READY:
  - On an edge with input_ready=1: latch A<=operand_A, B<=operand_B; go to CALC.
  - Otherwise stay.
- CALC, one step per clock, priority order:
  - if A<B: swap A and B.
  - else if B!=0: A<=A-B.
  - else (B==0): result_data<=A; go to DONE.
- DONE:
  - Hold result_data stable.
  - On an edge with result_taken=1: go to READY. input_available rises the next cycle.
- result_data keeps its last value outside DONE. It changes only on the CALC to DONE transition, or on reset.
- input_ready is ignored outside READY. result_taken is ignored outside DONE. Both are level-sampled on the clock edge and must be held at least one cycle.
- Arithmetic is unsigned width-bit. Subtraction never underflows, because the A<B check comes first. Values above 2^width-1 are not representable; callers truncate.
- Zero cases:
  - gcd(0,x)=x: swap, then B==0.
  - gcd(x,0)=x.
  - gcd(0,0)=0: DONE after one CALC cycle.
- Latency: start edge to result_rdy = number of CALC iterations + 1 cycles. Worst case is about 2^width cycles (e.g. gcd(255,1)); no timeout.
- Throughput: minimum one READY cycle between jobs.

Decomposition:
- Shared package gcd_pkg:
  - state enum (READY, CALC, DONE)
  - default width constant
- Natural sub-module gcd_datapath:
  - A/B registers, compare, swap, subtract mux, result register
  - driven by load/step controls
  - returns b_zero and a_lt_b
- gcd_top keeps the FSM and handshake decode.

Test Plan:
- Reset then idle: assert sys_rst 2 cycles -> input_available=1, result_rdy=0, result_data=0. No state change without input_ready.
- Single jobs, each with input_ready 1 cycle, then wait for result_rdy, then result_taken 1 cycle:
  - A=12, B=66 -> result_data=6
  - A=105, B=99 -> 3
  - A=24, B=18 -> 6
  - A=126, B=18 -> 18
- Zero/edge cases:
  - A=0, B=35 -> 35
  - A=35, B=0 -> 35
  - A=0, B=0 -> 0
  - A=255, B=1 -> 1; check cycle count equals iteration count + 1.
- Handshake holds:
  - Keep result_taken=0 for 20 cycles in DONE -> result_rdy and result_data stable, input_available=0.
  - Pulse input_ready during CALC -> ignored; operands unchanged.
- Reset mid-CALC on A=200, B=3 -> next cycle READY, result_rdy=0, result_data=0. A new job 24/18 then yields 6.
- Back-to-back loop of the four pairs above, cycled three times with randomized delays on input_ready and result_taken -> results repeat 6, 3, 6, 18 in order. Scoreboard each result against a reference gcd.
